cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//  Shares the single common data bus (cdb_t) among N_REQ result producers (ALU, FPU, load unit, branch unit).
//  Each producer owns a 1-entry holding register; the arbiter selects one held result per cycle, round-robin.
//  Selected result drives cdb to the ROB and reservation stations; tag_match() consumers are unchanged.
//  Branch-mispredict flush discards all held, not-yet-broadcast results.
// PARAMETERS
//  N_REQ      4          number of producers sharing the CDB (2..8)
//  ROB_WIDTH  (package)  tag width, taken from my_package; not overridden locally
// PORTS
//  clk         in   1                  clock; all state changes on posedge
//  rstn        in   1                  synchronous active-low reset
//  flush       in   1                  mispredict flush, synchronous, active-high
//  req_valid   in   N_REQ              producer i offers a result this cycle
//  req_tag     in   N_REQ x ROB_WIDTH  ROB tag of offered result
//  req_data    in   N_REQ x 32         offered result data
//  req_ready   out  N_REQ              holding register i can accept this cycle
//  cdb         out  cdb_t              broadcast {valid, tag, data}
//  grant       out  N_REQ              one-hot: entry broadcast this cycle (all 0 if none)
//  conflict_cnt out 32                 cycles with >=2 entries held (performance counter)
// BEHAVIOUR
//  - Reset (rstn=0 at posedge): all hold_valid=0, rr_ptr=0, conflict_cnt=0; hence cdb.valid=0, grant=0,
//    req_ready=all 1 in the next cycle. Reset wins over flush and over any request.
//  - Handshake: transfer on posedge when req_valid[i] && req_ready[i]; producer holds tag/data stable until then.
//  - req_ready[i] = !flush && (!hold_valid[i] || grant[i]); combinational, no dependence on req_valid (no loops).
//  - Latency: result accepted at edge N is broadcastable in cycle N+1 at the earliest; never same-cycle bypass.
//  - Arbitration (combinational, from registered state only): winner = first i with hold_valid[i], searching
//    rr_ptr, rr_ptr+1, ... mod N_REQ. grant = onehot(winner); cdb = {1, hold_tag[w], hold_data[w]}.
//    No valid entry: cdb.valid=0, grant=0, cdb.tag/data = 0.
//  - rr_ptr update: on a grant, rr_ptr <= (winner+1) mod N_REQ (wrap N_REQ-1 -> 0); no grant: unchanged.
//  - Hold entry i next state: accept -> load new tag/data, valid=1; else grant[i] -> valid=0; else hold.
//    Simultaneous grant[i] and accept on i: entry is overwritten with new result, valid stays 1 (full throughput
//    for a lone producer: one result per cycle).
//  - Starvation bound: a held entry is granted within N_REQ cycles of becoming valid.
//  - flush=1 at posedge: all hold_valid <= 0; req_ready=0 that cycle so no new accept; the combinational
//    broadcast of the current winner still happens this cycle (ROB discards by tag); rr_ptr still advances.
//  - conflict_cnt: +1 on each posedge where popcount(hold_valid)>=2 (before update); wraps 2^32-1 -> 0; flush does not clear it.
//  - Tag is not checked for uniqueness; producer/ROB guarantee distinct tags in flight.
// STRUCTURE
//  - Package additions: parameter N_CDB_REQ = 4; typedef struct {valid; tag; data} cdb_req_t reused for
//    hold registers (same layout as cdb_t; cdb_t itself unchanged).
//  - One sub-module: rr_picker #(N) (valid[N], ptr[$clog2(N)] -> onehot grant, index, any); purely
//    combinational, reusable for future issue-port arbitration.
//  - Hold registers, rr_ptr, conflict_cnt live in cdb_arbiter; all always_ff blocks use synchronous rstn.
// TESTING
//  1 Reset: rstn=0 2 cycles with req_valid=4'b1111 -> cdb.valid=0, grant=0, conflict_cnt=0; after release req_ready=4'b1111.
//  2 Single producer streaming: req 2 valid every cycle tags 1,2,3,4 -> cdb tags 1,2,3,4 on consecutive cycles
//    starting one cycle after first accept; req_ready[2] stays 1.
//  3 Round-robin: all four accept at edge N (tags 10,11,12,13), rr_ptr=0 -> grants 0,1,2,3 in cycles N+1..N+4;
//    conflict_cnt increments by 3; next lone request on 1 then granted immediately regardless of rr_ptr.
//  4 Wrap/fairness: rr_ptr=3, entries 0 and 3 held -> grant 3 then 0; rr_ptr ends at 1.
//  5 Flush: entries 1,2 held, flush=1 with req_valid[0]=1 -> that cycle req_ready=0 and entry 1 broadcast;
//    next cycle cdb.valid=0, no entry held, producer 0 accepted only in the following cycle.
//  6 Backpressure: entries 0..3 held, producer 3 re-offers tag 7 -> req_ready[3]=0 until grant[3], then accepted same edge,
//    tag 7 broadcast no earlier than the next cycle.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the common data bus and its arbiter: bus record, tag width,
// default producer count and a small popcount helper.
package cdb_arbiter_pkg;

  localparam int ROB_WIDTH = 6;
  localparam int N_CDB_REQ = 4;

  typedef struct packed {
    logic                 valid;
    logic [ROB_WIDTH-1:0] tag;
    logic [31:0]          data;
  } cdb_t;

  // Same layout as cdb_t; used for the per-producer holding registers.
  typedef struct packed {
    logic                 valid;
    logic [ROB_WIDTH-1:0] tag;
    logic [31:0]          data;
  } cdb_req_t;

  function automatic int unsigned popcount(input logic [7:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 8; i++) n += int'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer-side handshake and broadcast bus of the CDB arbiter.
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int N_REQ = N_CDB_REQ
);
  // Handshake: producer i transfers on a posedge where req_valid[i] && req_ready[i];
  // tag/data are held stable while valid and not ready. req_ready never depends on req_valid.
  logic [N_REQ-1:0]                req_valid;
  logic [N_REQ-1:0][ROB_WIDTH-1:0] req_tag;
  logic [N_REQ-1:0][31:0]          req_data;
  logic [N_REQ-1:0]                req_ready;
  cdb_t                            cdb;
  logic [N_REQ-1:0]                grant;

  modport master (output req_valid, req_tag, req_data,
                  input  req_ready, cdb, grant);
  modport slave  (input  req_valid, req_tag, req_data,
                  output req_ready, cdb, grant);
endinterface

// File: rtl/cdb_arbiter_rr_picker.sv
// Combinational round-robin picker: first set bit of valid searching from ptr upward, wrapping.
module rr_picker #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] index,
  output logic          any
);
  always_comb begin
    logic [PW:0] pos;
    grant = '0;
    index = '0;
    any   = 1'b0;
    pos   = '0;
    // Scan from farthest to nearest so the nearest valid entry is written last and wins.
    for (int k = N - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + (PW + 1)'(k);
      if (pos >= (PW + 1)'(N)) pos = pos - (PW + 1)'(N);
      if (valid[pos[PW-1:0]]) begin
        grant              = '0;
        grant[pos[PW-1:0]] = 1'b1;
        index              = pos[PW-1:0];
        any                = 1'b1;
      end
    end
  end
endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding register per producer, one round-robin
// broadcast per cycle, mispredict flush of all held results, conflict counter.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N_REQ = N_CDB_REQ
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          flush,
  cdb_arbiter_if.slave  bus,
  output logic [31:0]   conflict_cnt
);
  localparam int PW = $clog2(N_REQ);

  cdb_req_t         hold [N_REQ];
  logic [N_REQ-1:0] hold_valid;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] accept;
  logic [N_REQ-1:0] ready;
  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    win_idx;
  logic             win_any;

  always_comb begin
    hold_valid = '0;
    for (int i = 0; i < N_REQ; i++) hold_valid[i] = hold[i].valid;
  end

  rr_picker #(.N(N_REQ), .PW(PW)) u_picker (
    .valid (hold_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .index (win_idx),
    .any   (win_any)
  );

  // A granted entry frees its slot in the same cycle, so a lone producer streams at full rate.
  always_comb begin
    ready  = '0;
    accept = '0;
    for (int i = 0; i < N_REQ; i++) begin
      ready[i]  = !flush && (!hold_valid[i] || grant[i]);
      accept[i] = bus.req_valid[i] && ready[i];
    end
  end

  always_comb begin
    bus.cdb = '0;
    if (win_any) begin
      bus.cdb.valid = 1'b1;
      bus.cdb.tag   = hold[win_idx].tag;
      bus.cdb.data  = hold[win_idx].data;
    end
  end

  assign bus.grant     = grant;
  assign bus.req_ready = ready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < N_REQ; i++) hold[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (flush) begin
          hold[i].valid <= 1'b0;
        end else if (accept[i]) begin
          hold[i].valid <= 1'b1;
          hold[i].tag   <= bus.req_tag[i];
          hold[i].data  <= bus.req_data[i];
        end else if (grant[i]) begin
          hold[i].valid <= 1'b0;
        end
      end
    end
  end

  // The pointer still advances on a flush cycle because the broadcast did happen.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rr_ptr <= '0;
    end else if (win_any) begin
      rr_ptr <= (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      conflict_cnt <= '0;
    end else if (popcount(8'(hold_valid)) >= 2) begin
      conflict_cnt <= conflict_cnt + 32'd1;
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, streaming, round-robin, wrap, flush, backpressure.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] conflict_cnt;
  int          n_cmp = 0;
  int          n_err = 0;

  cdb_arbiter_if #(.N_REQ(4)) bus ();

  cdb_arbiter #(.N_REQ(4)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .flush        (flush),
    .bus          (bus),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dat(input logic [ROB_WIDTH-1:0] t);
    return 32'hC0DE_0000 | 32'(t);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start a cycle: after the negedge, drop all offers; caller then adds offers.
  task automatic begin_cycle();
    @(negedge clk);
    bus.req_valid = '0;
    flush = 1'b0;
  endtask

  task automatic offer(input int i, input logic [ROB_WIDTH-1:0] t);
    bus.req_valid[i] = 1'b1;
    bus.req_tag[i]   = t;
    bus.req_data[i]  = dat(t);
  endtask

  task automatic chk_bcast(input string tag, input logic [ROB_WIDTH-1:0] t, input logic [3:0] g);
    chk({tag, "_valid"}, 64'(bus.cdb.valid), 64'd1);
    chk({tag, "_tag"},   64'(bus.cdb.tag),   64'(t));
    chk({tag, "_data"},  64'(bus.cdb.data),  64'(dat(t)));
    chk({tag, "_grant"}, 64'(bus.grant),     64'(g));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_cdb"},   64'(bus.cdb),   64'd0);
    chk({tag, "_grant"}, 64'(bus.grant), 64'd0);
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_tag   = '0;
    bus.req_data  = '0;

    // Reset with all producers offering.
    @(negedge clk);
    rstn = 1'b0;
    for (int i = 0; i < 4; i++) offer(i, ROB_WIDTH'(i + 1));
    @(negedge clk);
    #1;
    chk_idle("rst");
    chk("rst_cnt", 64'(conflict_cnt), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    bus.req_valid = '0;
    #1;
    chk("rst_ready", 64'(bus.req_ready), 64'hF);
    chk_idle("rst_rel");

    // Single producer streaming on entry 2.
    begin_cycle(); offer(2, 6'd1); #1;
    chk("s_ready0", 64'(bus.req_ready[2]), 64'd1);
    chk_idle("s_first");
    begin_cycle(); offer(2, 6'd2); #1;
    chk_bcast("s_t1", 6'd1, 4'b0100);
    chk("s_ready1", 64'(bus.req_ready[2]), 64'd1);
    begin_cycle(); offer(2, 6'd3); #1;
    chk_bcast("s_t2", 6'd2, 4'b0100);
    begin_cycle(); offer(2, 6'd4); #1;
    chk_bcast("s_t3", 6'd3, 4'b0100);
    chk("s_ready3", 64'(bus.req_ready[2]), 64'd1);
    begin_cycle(); #1;
    chk_bcast("s_t4", 6'd4, 4'b0100);
    begin_cycle(); #1;
    chk_idle("s_end");
    chk("s_cnt", 64'(conflict_cnt), 64'd0);

    // Bring rr_ptr to 0 via a lone grant on entry 3.
    begin_cycle(); offer(3, 6'd20); #1;
    begin_cycle(); #1;
    chk_bcast("p_t20", 6'd20, 4'b1000);

    // Round-robin: all four accepted on one edge.
    begin_cycle();
    for (int i = 0; i < 4; i++) offer(i, ROB_WIDTH'(10 + i));
    #1;
    chk("rr_ready", 64'(bus.req_ready), 64'hF);
    begin_cycle(); #1;
    chk_bcast("rr_g0", 6'd10, 4'b0001);
    chk("rr_cnt0", 64'(conflict_cnt), 64'd0);
    begin_cycle(); #1;
    chk_bcast("rr_g1", 6'd11, 4'b0010);
    chk("rr_cnt1", 64'(conflict_cnt), 64'd1);
    begin_cycle(); #1;
    chk_bcast("rr_g2", 6'd12, 4'b0100);
    chk("rr_cnt2", 64'(conflict_cnt), 64'd2);
    begin_cycle(); #1;
    chk_bcast("rr_g3", 6'd13, 4'b1000);
    chk("rr_cnt3", 64'(conflict_cnt), 64'd3);
    begin_cycle(); offer(1, 6'd30); #1;
    chk_idle("rr_gap");
    chk("rr_cnt4", 64'(conflict_cnt), 64'd3);
    begin_cycle(); #1;
    chk_bcast("rr_lone1", 6'd30, 4'b0010);

    // Wrap: rr_ptr to 3 via a lone grant on entry 2, then entries 0 and 3 held.
    begin_cycle(); offer(2, 6'd40); #1;
    begin_cycle(); #1;
    chk_bcast("w_t40", 6'd40, 4'b0100);
    begin_cycle(); offer(0, 6'd41); offer(3, 6'd42); #1;
    begin_cycle(); #1;
    chk_bcast("w_g3", 6'd42, 4'b1000);
    begin_cycle(); #1;
    chk_bcast("w_g0", 6'd41, 4'b0001);
    chk("w_cnt", 64'(conflict_cnt), 64'd4);
    // rr_ptr should now be 1: with 0,1,2 held, entry 1 goes first.
    begin_cycle(); offer(0, 6'd43); offer(1, 6'd44); offer(2, 6'd45); #1;
    begin_cycle(); #1;
    chk_bcast("w_ptr1", 6'd44, 4'b0010);
    begin_cycle(); #1;
    chk_bcast("w_next2", 6'd45, 4'b0100);
    begin_cycle(); #1;
    chk_bcast("w_next0", 6'd43, 4'b0001);
    chk("w_cnt2", 64'(conflict_cnt), 64'd6);

    // Flush with entries 1 and 2 held (rr_ptr=1).
    begin_cycle(); offer(1, 6'd50); offer(2, 6'd51); #1;
    begin_cycle(); flush = 1'b1; offer(0, 6'd52); #1;
    chk("f_ready", 64'(bus.req_ready), 64'h0);
    chk_bcast("f_bcast", 6'd50, 4'b0010);
    begin_cycle(); offer(0, 6'd52); #1;
    chk_idle("f_after");
    chk("f_ready2", 64'(bus.req_ready), 64'hF);
    chk("f_cnt", 64'(conflict_cnt), 64'd7);
    begin_cycle(); #1;
    chk_bcast("f_p0", 6'd52, 4'b0001);

    // Backpressure: all held (rr_ptr=1), producer 3 re-offers tag 7.
    begin_cycle();
    for (int i = 0; i < 4; i++) offer(i, ROB_WIDTH'(60 + i));
    #1;
    begin_cycle(); offer(3, 6'd7); #1;
    chk("b_ready1", 64'(bus.req_ready), 64'b0010);
    chk_bcast("b_g1", 6'd61, 4'b0010);
    begin_cycle(); offer(3, 6'd7); #1;
    chk("b_ready2", 64'(bus.req_ready), 64'b0110);
    chk_bcast("b_g2", 6'd62, 4'b0100);
    begin_cycle(); offer(3, 6'd7); #1;
    chk("b_ready3", 64'(bus.req_ready), 64'b1110);
    chk_bcast("b_g3", 6'd63, 4'b1000);
    begin_cycle(); #1;
    chk_bcast("b_g0", 6'd60, 4'b0001);
    chk("b_cnt", 64'(conflict_cnt), 64'd10);
    begin_cycle(); #1;
    chk_bcast("b_t7", 6'd7, 4'b1000);
    chk("b_cnt2", 64'(conflict_cnt), 64'd11);
    begin_cycle(); #1;
    chk_idle("b_end");

    // Reset beats flush and requests mid-run.
    begin_cycle();
    rstn = 1'b0; flush = 1'b1;
    for (int i = 0; i < 4; i++) offer(i, ROB_WIDTH'(i + 33));
    #1;
    begin_cycle(); rstn = 1'b1; #1;
    chk_idle("r2");
    chk("r2_cnt", 64'(conflict_cnt), 64'd0);
    chk("r2_ready", 64'(bus.req_ready), 64'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
